// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from instruction memory and
// holds each fetched instruction with its PC until decode accepts it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_ready,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          inst,
    output logic [31:0]          inst_pc,
    output logic                 inst_valid,
    input  logic                 dec_ready,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic                 misalign,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    typedef enum logic [0:0] {StFetch, StHold} state_e;

    state_e                 state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [31:0]            inst_q, inst_d;
    logic [31:0]            inst_pc_q, inst_pc_d;
    logic                   misalign_q, misalign_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;

    logic accept;
    assign accept = (state_q == StHold) && dec_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        misalign_d = misalign_q;
        count_d    = count_q;

        // Decode consumes the held word even if a redirect lands in the same cycle.
        if (accept) begin
            count_d = count_q + 1'b1;
        end

        if (redirect) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            state_d = StFetch;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (imem_ready) begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        pc_d      = pc_q + 32'd4;
                        state_d   = StHold;
                    end
                end
                StHold: begin
                    if (dec_ready) begin
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            inst_q     <= 32'h0;
            inst_pc_q  <= 32'h0;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    assign imem_req    = (state_q == StFetch);
    assign inst_valid  = (state_q == StHold);
    assign imem_addr   = pc_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign misalign    = misalign_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random traffic,
// compared each cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        dec_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misalign;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .CNT_WIDTH(32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .dec_ready  (dec_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .misalign   (misalign),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Reference model: where fetch is pointing, whether an instruction is waiting for
    // decode (and which one), how many were delivered, and the misalign history.
    logic [31:0] m_next_addr;
    bit          m_waiting;
    logic [31:0] m_word;
    logic [31:0] m_word_addr;
    logic [31:0] m_delivered;
    bit          m_bad_target;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h2008_0005;
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        m_next_addr  = 32'h0;
        m_waiting    = 0;
        m_word       = 32'h0;
        m_word_addr  = 32'h0;
        m_delivered  = 32'h0;
        m_bad_target = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("imem_req", {31'b0, imem_req}, {31'b0, !m_waiting});
        chk("imem_addr", imem_addr, m_next_addr);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_waiting});
        chk("inst", inst, m_word);
        chk("inst_pc", inst_pc, m_word_addr);
        chk("misalign", {31'b0, misalign}, {31'b0, m_bad_target});
        chk("fetch_count", fetch_count, m_delivered);
    endtask

    // Called at a falling edge: check, drive one cycle of inputs, advance the model,
    // return at the next falling edge.
    task automatic cyc(input bit rdy, input bit dr, input bit redir, input logic [31:0] rpc);
        check_model();
        imem_ready  = rdy;
        imem_rdata  = rdy ? mem_word(m_next_addr) : $urandom;
        dec_ready   = dr;
        redirect    = redir;
        redirect_pc = rpc;
        if (m_waiting && dr) m_delivered = m_delivered + 1;
        if (redir) begin
            m_next_addr = rpc & ~32'd3;
            m_waiting   = 0;
            if (rpc % 4 != 0) m_bad_target = 1;
        end else if (!m_waiting && rdy) begin
            m_word      = mem_word(m_next_addr);
            m_word_addr = m_next_addr;
            m_next_addr = m_next_addr + 32'd4;
            m_waiting   = 1;
        end else if (m_waiting && dr) begin
            m_waiting = 0;
        end
        @(negedge clk);
    endtask

    task automatic drain_to_fetch();
        if (m_waiting) cyc(0, 1, 0, 32'h0);
    endtask

    logic [31:0] saved_inst, saved_pc, saved_cnt;

    initial begin
        reset       = 1'b1;
        imem_ready  = 1'b0;
        imem_rdata  = 32'h0;
        dec_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        model_reset();

        // 1. reset for three cycles, then first fetch
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        reset = 1'b0;
        cyc(1, 1, 0, 32'h0);
        chk("t1_inst", inst, 32'h2008_0005);
        chk("t1_inst_pc", inst_pc, 32'h0);
        chk("t1_valid", {31'b0, inst_valid}, 32'h1);
        cyc(1, 1, 0, 32'h0);
        chk("t1_next_addr", imem_addr, 32'h4);

        // 2. sequential stream of four words from address 0
        cyc(1, 1, 1, 32'h0);
        saved_cnt = m_delivered;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 0, 32'h0);
            if (i % 2 == 0) chk("t2_inst_pc", inst_pc, 32'(i * 2));
        end
        chk("t2_count", fetch_count, saved_cnt + 32'd4);

        // 3. memory stall, then decode stall
        saved_pc = m_next_addr;
        repeat (3) cyc(0, 1, 0, 32'h0);
        chk("t3_addr_held", imem_addr, saved_pc);
        cyc(1, 0, 0, 32'h0);
        saved_inst = inst;
        saved_cnt  = fetch_count;
        repeat (5) cyc(0, 0, 0, 32'h0);
        chk("t3_inst_held", inst, saved_inst);
        chk("t3_count_held", fetch_count, saved_cnt);
        cyc(0, 1, 0, 32'h0);
        chk("t3_count_inc", fetch_count, saved_cnt + 32'd1);

        // 4. redirect colliding with a memory response, then with an acceptance
        drain_to_fetch();
        saved_inst = inst;
        cyc(1, 0, 1, 32'h0000_0040);
        chk("t4_addr", imem_addr, 32'h40);
        chk("t4_inst_kept", inst, saved_inst);
        cyc(1, 0, 0, 32'h0);
        saved_cnt = fetch_count;
        cyc(0, 1, 1, 32'h0000_0100);
        chk("t4_count", fetch_count, saved_cnt + 32'd1);
        chk("t4_valid_drop", {31'b0, inst_valid}, 32'h0);

        // 5. misaligned target, then PC wrap
        cyc(0, 0, 1, 32'h0000_0043);
        chk("t5_addr", imem_addr, 32'h40);
        chk("t5_misalign", {31'b0, misalign}, 32'h1);
        cyc(0, 0, 1, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 32'h0);
        chk("t5_wrap_pc", inst_pc, 32'hFFFF_FFFC);
        cyc(0, 1, 0, 32'h0);
        chk("t5_wrap_addr", imem_addr, 32'h0);
        chk("t5_sticky", {31'b0, misalign}, 32'h1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt = tgt & 32'h0000_0FFC;
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                $urandom_range(0, 99) < 8, tgt);
        end

        // 6. asynchronous reset while holding an instruction
        drain_to_fetch();
        cyc(0, 0, 1, 32'h0000_0201);
        cyc(1, 0, 0, 32'h0);
        chk("t6_pre_valid", {31'b0, inst_valid}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("t6_valid", {31'b0, inst_valid}, 32'h0);
        chk("t6_count", fetch_count, 32'h0);
        chk("t6_misalign", {31'b0, misalign}, 32'h0);
        chk("t6_pc", imem_addr, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, 32'h0);
        end
        check_model();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
